// File: rtl/mcycle_control.sv
// -----------------------------------------------------------------------------
// mcycle_control
//   Main control unit of a multi-cycle MIPS-style datapath. This is a Moore
//   FSM: the 4-bit state register steps through each instruction's phases, and
//   every datapath strobe/select is decoded from that register alone.
//
//   Configuration macro: MCYCLE_ADDI_EN
//     - When defined, op=001000 (addi) goes DECODE->ADDIEX->ADDIWB->FETCH.
//     - When undefined, addi is treated as an unsupported op. ADDIEX and
//       ADDIWB then behave like encodings 12-15: all outputs are 0 and the
//       next state is FETCH.
//
// Ports
//   clk                  : clock; state updates on the rising edge
//   reset                : asynchronous active-high; forces FETCH at once
//   op[5:0]              : opcode from the instruction register
//   pcwrite, pcwritecond : PC write enable / conditional (branch) PC write
//   iord                 : memory address select (0 = PC, 1 = ALUOut)
//   memread, memwrite    : memory strobes
//   memtoreg             : register write-data select (1 = MDR)
//   irwrite              : instruction register load
//   alusrca              : ALU A select (0 = PC, 1 = rs)
//   regwrite, regdst     : register file write enable / dest select (1 = rd)
//   aluop1, aluop0       : ALU class: 00 add, 01 subtract, 10 R-type
//   alusrcb[1:0]         : ALU B select (00 rt, 01 const 4, 10 imm, 11 imm<<2)
//   pcsource[1:0]        : next-PC select (00 ALU, 01 ALUOut, 10 jump target)
//   state[3:0]           : current state encoding (debug/observation)
// -----------------------------------------------------------------------------
module mcycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       alusrca,
  output logic       regwrite,
  output logic       regdst,
  output logic       aluop1,
  output logic       aluop0,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RTWB   = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef MCYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

  state_t     state_q, state_d;
  logic [1:0] aluop;

  // Next-state logic. Unused encodings (12-15, and the addi states when the
  // feature is off) fall into the default arm and return to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JUMP;
`ifdef MCYCLE_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RTWB;
`ifdef MCYCLE_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Moore output decode. Because this reads the state register directly, the
  // FETCH values appear as soon as reset forces the register, with no edge.
  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    alusrca     = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    aluop       = 2'b00;
    alusrcb     = 2'b00;
    pcsource    = 2'b00;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        irwrite = 1'b1;
        alusrcb = 2'b01;
        pcwrite = 1'b1;
      end
      S_DECODE: alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_RTWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQ: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
        pcsource    = 2'b01;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = 2'b10;
      end
`ifdef MCYCLE_ADDI_EN
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: regwrite = 1'b1;
`endif
      default: ;
    endcase
  end

  assign aluop1 = aluop[1];
  assign aluop0 = aluop[0];
  assign state  = state_q;

endmodule

// File: doc/mcycle_control.md
MCYCLE_CONTROL -- requirements
Module: mcycle_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces state to FETCH immediately.
REQ-004 op  input  6  opcode field from the instruction register; must be stable from DECODE onward.
REQ-005 pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite, alusrca, regwrite, regdst  output  1 each  datapath strobes and selects.
REQ-006 aluop1, aluop0  output  1 each  ALU-op class for the downstream ALU control decoder: 00 add, 01 subtract, 10 R-type (funct decoded downstream).
REQ-007 alusrcb, pcsource  output  2 each  ALU B-operand select and next-PC source select.
REQ-008 state  output  4  current state encoding, for debug and bench observation.

Function
REQ-009 The block SHALL be a Moore FSM: every output SHALL be decoded combinationally from the state register only.
REQ-010 State encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RTWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11; encodings 12-15 SHALL transition to FETCH.
REQ-011 Transitions: FETCH->DECODE; DECODE by op: 100011/101011->MEMADR, 000000->EXEC, 000100->BEQ, 000010->JUMP, any other op->FETCH.
REQ-012 Further transitions: MEMADR->MEMRD if op=100011, else MEMWR; MEMRD->MEMWB; EXEC->RTWB; ADDIEX->ADDIWB; MEMWB, MEMWR, RTWB, BEQ, JUMP and ADDIWB->FETCH.
REQ-013 FETCH outputs: memread=1, irwrite=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcwrite=1, pcsource=00.
REQ-014 DECODE outputs: alusrca=0, alusrcb=11, aluop=00. MEMADR outputs: alusrca=1, alusrcb=10, aluop=00.
REQ-015 MEMRD outputs: memread=1, iord=1. MEMWR outputs: memwrite=1, iord=1. MEMWB outputs: regwrite=1, memtoreg=1, regdst=0.
REQ-016 EXEC outputs: alusrca=1, alusrcb=00, aluop=10. RTWB outputs: regwrite=1, regdst=1, memtoreg=0.
REQ-017 BEQ outputs: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01. JUMP outputs: pcwrite=1, pcsource=10.
REQ-018 ADDIEX outputs: alusrca=1, alusrcb=10, aluop=00. ADDIWB outputs: regwrite=1, regdst=0, memtoreg=0.
REQ-019 Every output not listed for a state SHALL be 0 in that state; in states 12-15 all outputs SHALL be 0.
REQ-020 Instruction latency in cycles, FETCH to FETCH inclusive: lw 5, sw 4, R-type 4, beq 3, j 3, addi 4, unsupported op 2.
REQ-021 memread and memwrite SHALL never both be 1; pcwrite and pcwritecond SHALL never both be 1.
REQ-022 An unsupported op SHALL cause no register, memory or PC write after FETCH.

Reset
REQ-023 On reset assertion, state SHALL become FETCH asynchronously, and the outputs SHALL take the FETCH values immediately: memread=1, irwrite=1, pcwrite=1, alusrcb=01, all others 0.
REQ-024 Reset asserted in any state, including mid-instruction, SHALL abort the instruction; state SHALL remain FETCH while reset is high.
REQ-025 After reset deasserts, the first rising edge SHALL move the FSM to DECODE.

Configuration
REQ-026 Macro MCYCLE_ADDI_EN: when defined, DECODE with op=001000 SHALL go to ADDIEX.
REQ-027 When MCYCLE_ADDI_EN is undefined, op=001000 SHALL be unsupported and go DECODE->FETCH, and states ADDIEX and ADDIWB SHALL behave as states 12-15.

Verification
REQ-028 lw test: reset pulse, then op=100011 -> state sequence 0,1,2,3,4,0; memread=1 in state 3; regwrite=1 and memtoreg=1 in state 4 only.
REQ-029 R-type and sw tests: op=000000 -> sequence 0,1,6,7,0 with aluop=10 in state 6 and regdst=1, regwrite=1 in state 7; op=101011 -> sequence 0,1,2,5,0 with memwrite=1 and iord=1 in state 5.
REQ-030 Branch and jump tests: op=000100 -> sequence 0,1,8,0 with aluop=01, pcwritecond=1, pcsource=01 in state 8; op=000010 -> sequence 0,1,9,0 with pcwrite=1, pcsource=10 in state 9.
REQ-031 addi and illegal-op tests: op=001000 with MCYCLE_ADDI_EN -> sequence 0,1,10,11,0; op=001000 without the macro, and op=111111 -> sequence 0,1,0 with regwrite=memwrite=0 throughout.
REQ-032 Reset test: assert reset mid-cycle in state 3 -> state=0 before the next clock edge, with memread=1 and irwrite=1; hold reset for 3 edges -> state stays 0.
